// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexes four hex digits onto one active-low 7-segment bus.
// Latency: an/seg are registered one clock after the prescaler, slot and shadow state.
// Backpressure: none. en=0 freezes the scan position and blanks the display.
module seg7_scan_driver #(
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_CYC   = 500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [4:0] digit0,
  input  logic [4:0] digit1,
  input  logic [4:0] digit2,
  input  logic [4:0] digit3,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       frame_done
);

  // Prescaler width; REFRESH_DIV >= 2 keeps this at least one bit.
  localparam int            CW       = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

  // A blanked digit: bit 4 set, value bits don't care.
  localparam logic [4:0] SH_BLANK  = 5'b10000;
  localparam logic [3:0] AN_OFF    = 4'b1111;
  localparam logic [6:0] SEG_OFF   = 7'b1111111;

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [4:0]    sh0, sh1, sh2, sh3;
  logic          tick;
  logic          frame_end;
  logic [4:0]    cur;
  logic          in_blank;
  logic          dark;
  logic [6:0]    seg_on;
  logic [3:0]    an_nxt;
  logic [6:0]    seg_nxt;

  assign tick      = en && (cnt == CNT_LAST);
  assign frame_end = tick && (idx == 2'd3);

  // Anti-ghosting window at the start of each slot. With no window the
  // compare would be constant, so it is left out entirely.
  generate
    if (BLANK_CYC == 0) begin : g_noblank
      assign in_blank = 1'b0;
    end else begin : g_blank
      localparam logic [CW-1:0] BLANK_LIM = CW'(BLANK_CYC);
      assign in_blank = (cnt < BLANK_LIM);
    end
  endgenerate

  // Prescaler: counts clocks within the current slot, frozen while disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt == CNT_LAST) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Slot index: steps to the next digit at the end of each slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= 2'd0;
    end else if (tick) begin
      idx <= idx + 2'd1;
    end
  end

  // Shadow copies of the digits, refreshed only at the frame boundary so a
  // frame never shows a mix of old and new values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh0 <= SH_BLANK;
      sh1 <= SH_BLANK;
      sh2 <= SH_BLANK;
      sh3 <= SH_BLANK;
    end else if (frame_end) begin
      sh0 <= digit0;
      sh1 <= digit1;
      sh2 <= digit2;
      sh3 <= digit3;
    end
  end

  // Select the shadow belonging to the slot being displayed.
  always_comb begin
    cur = sh0;
    case (idx)
      2'd0: cur = sh0;
      2'd1: cur = sh1;
      2'd2: cur = sh2;
      2'd3: cur = sh3;
      default: cur = sh0;
    endcase
  end

  // Hex to active-high segment pattern, {g,f,e,d,c,b,a}.
  always_comb begin
    seg_on = 7'h00;
    case (cur[3:0])
      4'h0: seg_on = 7'h3F;
      4'h1: seg_on = 7'h06;
      4'h2: seg_on = 7'h5B;
      4'h3: seg_on = 7'h4F;
      4'h4: seg_on = 7'h66;
      4'h5: seg_on = 7'h6D;
      4'h6: seg_on = 7'h7D;
      4'h7: seg_on = 7'h07;
      4'h8: seg_on = 7'h7F;
      4'h9: seg_on = 7'h6F;
      4'hA: seg_on = 7'h77;
      4'hB: seg_on = 7'h7C;
      4'hC: seg_on = 7'h39;
      4'hD: seg_on = 7'h5E;
      4'hE: seg_on = 7'h79;
      4'hF: seg_on = 7'h71;
      default: seg_on = 7'h00;
    endcase
  end

  assign dark = !en || in_blank || cur[4];

  // Next display drive: all off when dark, else one anode low for this slot.
  always_comb begin
    an_nxt  = AN_OFF;
    seg_nxt = SEG_OFF;
    if (!dark) begin
      an_nxt[idx] = 1'b0;
      seg_nxt     = ~seg_on;
    end
  end

  // Output registers; reset forces the display dark without a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an         <= AN_OFF;
      seg        <= SEG_OFF;
      frame_done <= 1'b0;
    end else begin
      an         <= an_nxt;
      seg        <= seg_nxt;
      frame_done <= frame_end;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed checks of the 4-digit scan driver.
// Main instance uses REFRESH_DIV=4, BLANK_CYC=1; a second instance has no blank window.
// Outputs are sampled 1 time unit after each rising edge.
module tb_seg7_scan_driver;

  typedef struct {
    logic       en;
    logic [3:0] an;
    logic [6:0] seg;
    logic       fd;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       en;
  logic [4:0] digit0, digit1, digit2, digit3;
  logic [3:0] an;
  logic [6:0] seg;
  logic       frame_done;

  logic       rst1;
  logic       en1;
  logic [4:0] e0, e1, e2, e3;
  logic [3:0] an1;
  logic [6:0] seg1;
  logic       fd1;

  int checks = 0;
  int errors = 0;

  logic [6:0] hex_tab [16];
  vec_t       tab [32];

  seg7_scan_driver #(.REFRESH_DIV(4), .BLANK_CYC(1)) u_dut (
    .clk(clk), .rst(rst), .en(en),
    .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3),
    .an(an), .seg(seg), .frame_done(frame_done)
  );

  seg7_scan_driver #(.REFRESH_DIV(4), .BLANK_CYC(0)) u_nob (
    .clk(clk), .rst(rst1), .en(en1),
    .digit0(e0), .digit1(e1), .digit2(e2), .digit3(e3),
    .an(an1), .seg(seg1), .frame_done(fd1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cycle(input string nm, input logic [3:0] ean, input logic [6:0] eseg,
                             input logic efd);
    step();
    chk({nm, ".an"}, {4'h0, an}, {4'h0, ean});
    chk({nm, ".seg"}, {1'b0, seg}, {1'b0, eseg});
    chk({nm, ".fd"}, {7'h0, frame_done}, {7'h0, efd});
  endtask

  // Four clocks of one slot: first clock blank, then lit unless the digit is blanked.
  task automatic check_slot(input string nm, input int s, input logic [4:0] d, input logic last);
    logic [3:0] one;
    logic       blank;
    one = 4'b0001 << s;
    for (int p = 0; p < 4; p++) begin
      blank = (p == 0) || d[4];
      check_cycle($sformatf("%s.s%0d.p%0d", nm, s, p),
                  blank ? 4'hF : ~one,
                  blank ? 7'h7F : ~hex_tab[d[3:0]],
                  last && (p == 3));
    end
  endtask

  task automatic check_frame(input string nm, input logic [4:0] d0, input logic [4:0] d1,
                             input logic [4:0] d2, input logic [4:0] d3);
    check_slot(nm, 0, d0, 1'b0);
    check_slot(nm, 1, d1, 1'b0);
    check_slot(nm, 2, d2, 1'b0);
    check_slot(nm, 3, d3, 1'b1);
  endtask

  function automatic vec_t mk(input logic ven, input logic [3:0] van, input logic [6:0] vseg,
                              input logic vfd);
    vec_t v;
    v.en  = ven;
    v.an  = van;
    v.seg = vseg;
    v.fd  = vfd;
    return v;
  endfunction

  initial begin
    hex_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Frame 1: shadows still blank; frame_done after the 16th clock.
    for (int i = 0; i < 16; i++) tab[i] = mk(1'b1, 4'hF, 7'h7F, (i == 15));
    // Frame 2: digits 1,2,3,4; blank clock at the start of every slot.
    tab[16] = mk(1'b1, 4'hF, 7'h7F, 1'b0);
    tab[17] = mk(1'b1, 4'hE, 7'h79, 1'b0);
    tab[18] = mk(1'b1, 4'hE, 7'h79, 1'b0);
    tab[19] = mk(1'b1, 4'hE, 7'h79, 1'b0);
    tab[20] = mk(1'b1, 4'hF, 7'h7F, 1'b0);
    tab[21] = mk(1'b1, 4'hD, 7'h24, 1'b0);
    tab[22] = mk(1'b1, 4'hD, 7'h24, 1'b0);
    tab[23] = mk(1'b1, 4'hD, 7'h24, 1'b0);
    tab[24] = mk(1'b1, 4'hF, 7'h7F, 1'b0);
    tab[25] = mk(1'b1, 4'hB, 7'h30, 1'b0);
    tab[26] = mk(1'b1, 4'hB, 7'h30, 1'b0);
    tab[27] = mk(1'b1, 4'hB, 7'h30, 1'b0);
    tab[28] = mk(1'b1, 4'hF, 7'h7F, 1'b0);
    tab[29] = mk(1'b1, 4'h7, 7'h19, 1'b0);
    tab[30] = mk(1'b1, 4'h7, 7'h19, 1'b0);
    tab[31] = mk(1'b1, 4'h7, 7'h19, 1'b1);

    rst = 1'b0; rst1 = 1'b0;
    en = 1'b0; en1 = 1'b0;
    digit0 = 5'h00; digit1 = 5'h00; digit2 = 5'h00; digit3 = 5'h00;
    e0 = 5'h00; e1 = 5'h00; e2 = 5'h00; e3 = 5'h00;
    #1;
    rst = 1'b1; rst1 = 1'b1;
    #2;
    chk("reset.an", {4'h0, an}, 8'h0F);
    chk("reset.seg", {1'b0, seg}, 8'h7F);
    chk("reset.fd", {7'h0, frame_done}, 8'h00);
    step();
    step();
    rst = 1'b0;
    en = 1'b1;
    digit0 = 5'h01; digit1 = 5'h02; digit2 = 5'h03; digit3 = 5'h04;

    for (int k = 0; k < 32; k++) begin
      en = tab[k].en;
      check_cycle($sformatf("tab%0d", k), tab[k].an, tab[k].seg, tab[k].fd);
    end

    // Mid-frame change of digit2 has no effect until the next boundary.
    digit2 = 5'h10;
    check_frame("f3", 5'h01, 5'h02, 5'h03, 5'h04);
    digit0 = 5'h08;
    check_frame("f4", 5'h01, 5'h02, 5'h10, 5'h04);
    digit0 = 5'h0A;
    check_frame("f5", 5'h08, 5'h02, 5'h10, 5'h04);
    digit2 = 5'h03;
    check_frame("f6", 5'h0A, 5'h02, 5'h10, 5'h04);

    // Frame 7: pause for 6 clocks in the middle of slot 2.
    check_slot("f7", 0, 5'h0A, 1'b0);
    check_slot("f7", 1, 5'h02, 1'b0);
    check_cycle("f7.s2.p0", 4'hF, 7'h7F, 1'b0);
    check_cycle("f7.s2.p1", 4'hB, 7'h30, 1'b0);
    en = 1'b0;
    for (int i = 0; i < 6; i++) check_cycle($sformatf("f7.pause%0d", i), 4'hF, 7'h7F, 1'b0);
    en = 1'b1;
    check_cycle("f7.s2.p2", 4'hB, 7'h30, 1'b0);
    check_cycle("f7.s2.p3", 4'hB, 7'h30, 1'b0);
    check_slot("f7", 3, 5'h04, 1'b1);

    // Frame 8: reset in slot 3 darkens outputs without a clock edge.
    check_slot("f8", 0, 5'h0A, 1'b0);
    check_slot("f8", 1, 5'h02, 1'b0);
    check_slot("f8", 2, 5'h03, 1'b0);
    check_cycle("f8.s3.p0", 4'hF, 7'h7F, 1'b0);
    check_cycle("f8.s3.p1", 4'h7, 7'h19, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid.an", {4'h0, an}, 8'h0F);
    chk("rst_mid.seg", {1'b0, seg}, 8'h7F);
    chk("rst_mid.fd", {7'h0, frame_done}, 8'h00);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("rst_hold%0d.fd", i), {7'h0, frame_done}, 8'h00);
      chk($sformatf("rst_hold%0d.an", i), {4'h0, an}, 8'h0F);
    end
    rst = 1'b0;
    check_frame("f9", 5'h10, 5'h10, 5'h10, 5'h10);
    check_frame("f10", 5'h0A, 5'h02, 5'h03, 5'h04);

    // No blank window: sweep all 16 hex values, four per frame.
    rst1 = 1'b0;
    en1  = 1'b1;
    for (int g = 0; g < 5; g++) begin
      if (g < 4) begin
        e0 = {1'b0, 4'(4 * g + 0)};
        e1 = {1'b0, 4'(4 * g + 1)};
        e2 = {1'b0, 4'(4 * g + 2)};
        e3 = {1'b0, 4'(4 * g + 3)};
      end
      for (int s = 0; s < 4; s++) begin
        for (int p = 0; p < 4; p++) begin
          logic [3:0] one;
          step();
          one = 4'b0001 << s;
          if (g == 0) begin
            chk($sformatf("nob.g0.s%0d.p%0d.an", s, p), {4'h0, an1}, 8'h0F);
          end else begin
            chk($sformatf("nob.g%0d.s%0d.p%0d.an", g, s, p), {4'h0, an1}, {4'h0, ~one});
            chk($sformatf("nob.g%0d.s%0d.p%0d.seg", g, s, p), {1'b0, seg1},
                {1'b0, ~hex_tab[4 * (g - 1) + s]});
            chk($sformatf("nob.g%0d.s%0d.p%0d.onehot", g, s, p),
                8'($countones(~an1)), 8'd1);
          end
          chk($sformatf("nob.g%0d.s%0d.p%0d.fd", g, s, p), {7'h0, fd1},
              {7'h0, (s == 3 && p == 3)});
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
